// File: rtl/larson_scan_ctrl.sv
// larson_scan_ctrl: controlled sequencer for the Larson-scanner LED bank.
// Steps a position either at a programmable rate (RUN) or one step per
// rising edge of step_req (IDLE/PAUSE). Bounce mode sweeps back and forth
// between the ends; wrap mode runs up and restarts at 0. pos, dir, led and
// step_pulse are all registered and change together on an advance edge.
module larson_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int POS_W = 3,
    parameter int DIV_W = 4
) (
    input  logic             slowclk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             mode,
    input  logic [DIV_W-1:0] speed,
    output logic [POS_W-1:0] pos,
    output logic             dir,
    output logic [WIDTH-1:0] led,
    output logic             step_pulse,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Top LED index and the one just below it (bounce turn-around target).
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_PEN  = POS_W'(WIDTH - 2);

    state_t           state_q;
    logic [DIV_W-1:0] cnt;
    logic             step_req_q;
    logic             step_edge;
    logic             tick;
    logic             advance;
    logic [POS_W-1:0] pos_nxt;
    logic             dir_nxt;

    // A held-high step_req yields one edge only.
    assign step_edge = step_req & ~step_req_q;

    // Rate tick: >= (not ==) so lowering speed mid-count fires at once
    // instead of waiting for the counter to wrap.
    assign tick = (state_q == S_RUN) && (cnt >= speed);

    // Manual steps count only outside RUN, and lose to a simultaneous run_en.
    assign advance = tick || ((state_q != S_RUN) && step_edge && !run_en);

    assign state = state_q;

    // Next position/direction if an advance happens this cycle.
    always_comb begin
        // NOTE: defaults assigned first so no path leaves a signal unassigned (no latch).
        pos_nxt = pos;
        dir_nxt = dir;
        if (mode) begin
            pos_nxt = (pos == POS_LAST) ? '0 : pos + 1'b1;
            dir_nxt = 1'b0;
        end else if (!dir) begin
            if (pos == POS_LAST) begin
                pos_nxt = POS_PEN;
                dir_nxt = 1'b1;
            end else begin
                pos_nxt = pos + 1'b1;
            end
        end else begin
            if (pos == '0) begin
                pos_nxt = POS_W'(1);
                dir_nxt = 1'b0;
            end else begin
                pos_nxt = pos - 1'b1;
            end
        end
    end

    // FSM, prescaler, step-edge register and registered scanner outputs.
    always_ff @(posedge slowclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt        <= '0;
            step_req_q <= 1'b0;
            pos        <= '0;
            dir        <= 1'b0;
            led        <= WIDTH'(1);
            step_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            step_req_q <= step_req;
            step_pulse <= advance;

            if (advance) begin
                pos <= pos_nxt;
                dir <= dir_nxt;
                led <= WIDTH'(1) << pos_nxt;
            end

            case (state_q)
                S_IDLE: begin
                    if (run_en)         state_q <= S_RUN;
                    else if (step_edge) state_q <= S_PAUSE;
                end
                S_RUN: begin
                    if (!run_en) state_q <= S_PAUSE;
                end
                S_PAUSE: begin
                    if (run_en) state_q <= S_RUN;
                end
                default: state_q <= S_IDLE;
            endcase

            if (state_q == S_RUN) cnt <= tick ? '0 : cnt + 1'b1;
            else                  cnt <= '0;
        end
    end

endmodule
